mp_add_seq: RTL
===============

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around a single 8-bit adder slice (a + b + carry, with sign, overflow and carry flags).
- Processes NBYTES-wide operands one byte per clock, least-significant byte first, chaining the carry.
- Sits between the control logic and the byte-wide arithmetic datapath, so wide integer operations reuse one 8-bit adder.

Parameters:
- NBYTES, 4, operand width in bytes (legal range 1..16); operand width W = 8*NBYTES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- op_sub  input  1  0 = A+B+carry_in; 1 = A-B; sampled with start.
- carry_in  input  1  initial carry for add; ignored when op_sub=1.
- a_in  input  W  operand A; sampled with start.
- b_in  input  W  operand B; sampled with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when the result and flags are valid.
- result  output  W  sum or difference; held until the next accepted start.
- sign  output  1  result[W-1].
- overflow  output  1  signed (two's complement) overflow of the full-width operation.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values: FSM=IDLE, ready=1, done=0, result=0, sign=0, overflow=0, carry_out=0, zero=0, byte index=0, internal carry=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch a_in and b_in.
  - For subtract, latch ~b_in in place of b_in.
  - Set internal carry to (op_sub ? 1 : carry_in) and byte index to 0.
  - Clear the result register; go to RUN.
  - ready drops the cycle after start is accepted.
- RUN, each cycle with index i:
  - Compute {c, s} = A[i] + B'[i] + carry as a 9-bit sum.
  - Write s to result byte i and set carry = c.
  - If i == NBYTES-1, go to DONE; otherwise i = i+1.
- Flags are captured when the top byte is processed:
  - sign = s[7].
  - overflow = (A[top][7] == B'[top][7]) && (s[7] != A[top][7]).
  - carry_out = c.
  - zero = all result bytes, including byte top, equal to 0.
- DONE: done=1 for exactly one cycle, then go to IDLE with ready=1.
- Latency: start accepted at edge t; done is high in the cycle following edge t+NBYTES+1, i.e. NBYTES+2 cycles from start to done.
- start while ready=0 is ignored entirely; no queuing.
- Outputs are stable from DONE until the next accepted start. In RUN, result shows partial bytes and the flags hold their old values; consumers use done.
- NBYTES=1: RUN lasts one cycle; behaviour is identical to a single slice.
- Wrap-around: the result is modulo 2^W; carry_out reports the lost bit.
- Reset during RUN or DONE: abort, return to IDLE, clear all outputs to their reset values; no done pulse.
- start asserted in the same cycle as reset: ignored.

Optional Feature:
- Macro MP_ADD_SEQ_ACCUM_EN adds input port accum (1 bit, sampled with start).
- When accum=1, operand A is taken from the current result register instead of a_in, enabling running sums.
- Without the macro, the port is absent and A always comes from a_in.

Test Plan:
- NBYTES=4, add 0x000000FF + 0x00000001, carry_in=0:
  - result=0x00000100, carry_out=0, overflow=0, sign=0, zero=0.
  - done exactly 6 cycles after the start edge.
- Add 0x7FFFFFFF + 0x00000001 -> result=0x80000000, overflow=1, sign=1, carry_out=0.
- Add 0xFFFFFFFF + 0x00000000 with carry_in=1 -> result=0x00000000, carry_out=1, zero=1, overflow=0.
- Subtract 0x00000005 - 0x00000007 -> result=0xFFFFFFFE, carry_out=0, sign=1, overflow=0.
- Subtract 0x80000000 - 0x00000001 -> result=0x7FFFFFFF, overflow=1, carry_out=1.
- Control sequence:
  - Pulse start with a second operand set while busy -> ignored; the first result is unchanged.
  - Assert reset in RUN -> no done pulse, outputs=0, ready=1 on the next cycle.
  - With MP_ADD_SEQ_ACCUM_EN, three accum adds of 0x10 -> result=0x30.

Source files
------------

// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: request/result bundle between a controller (master) and the mp_add_seq sequencer (slave)
// Signals: start, op_sub, carry_in, a_in, b_in (request, plus accum when MP_ADD_SEQ_ACCUM_EN is defined);
//          ready, done, result, sign, overflow, carry_out, zero (status and result).
interface mp_add_seq_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;
   logic start, op_sub, carry_in;
   logic [W-1:0] a_in, b_in;
`ifdef MP_ADD_SEQ_ACCUM_EN
   logic accum;
`endif
   logic ready, done, sign, overflow, carry_out, zero;
   logic [W-1:0] result;
   modport master (
      output start, op_sub, carry_in, a_in, b_in,
`ifdef MP_ADD_SEQ_ACCUM_EN
      output accum,
`endif
      input ready, done, result, sign, overflow, carry_out, zero
   );
   modport slave (
      input start, op_sub, carry_in, a_in, b_in,
`ifdef MP_ADD_SEQ_ACCUM_EN
      input accum,
`endif
      output ready, done, result, sign, overflow, carry_out, zero
   );
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: NBYTES-wide add/subtract computed one byte per clock, LSB first, through one 8-bit adder slice
// Ports: clk, reset (synchronous, active-high); bus (mp_add_seq_if.slave) carries start/op_sub/carry_in/a_in/b_in
//        in and ready/done/result/sign/overflow/carry_out/zero out.
// Optional: defining MP_ADD_SEQ_ACCUM_EN adds bus.accum, which takes operand A from the current result.
module mp_add_seq #(
   parameter int NBYTES = 4
) (
   input logic         clk,
   input logic         reset,
   mp_add_seq_if.slave bus
);
   localparam int W = 8 * NBYTES;
   localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q;
   logic [W-1:0] a_q, b_q, res_q, res_d, a_sel;
   logic [IW-1:0] idx_q;
   logic carry_q, done_q, sign_q, ovf_q, cout_q, zero_q;
   logic [7:0] a_byte, b_byte;
   logic [8:0] sum_d;
`ifdef MP_ADD_SEQ_ACCUM_EN
   assign a_sel = bus.accum ? res_q : bus.a_in;
`else
   assign a_sel = bus.a_in;
`endif
   // res_d is the result with the current byte merged in, so zero sees the top byte too
   always_comb begin
      a_byte = a_q[{idx_q, 3'b000} +: 8];
      b_byte = b_q[{idx_q, 3'b000} +: 8];
      sum_d = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
      res_d = res_q;
      res_d[{idx_q, 3'b000} +: 8] = sum_d[7:0];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         idx_q <= '0;
         carry_q <= 1'b0;
         done_q <= 1'b0;
         sign_q <= 1'b0;
         ovf_q <= 1'b0;
         cout_q <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         done_q <= state_q == DONE;
         case (state_q)
            IDLE: if (bus.start) begin
               a_q <= a_sel;
               b_q <= bus.op_sub ? ~bus.b_in : bus.b_in;
               // subtract is A + ~B + 1
               carry_q <= bus.op_sub | bus.carry_in;
               idx_q <= '0;
               res_q <= '0;
               state_q <= RUN;
            end
            RUN: begin
               res_q <= res_d;
               carry_q <= sum_d[8];
               if (idx_q == LAST) begin
                  sign_q <= sum_d[7];
                  ovf_q <= (a_byte[7] == b_byte[7]) && (sum_d[7] != a_byte[7]);
                  cout_q <= sum_d[8];
                  zero_q <= res_d == '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.ready = state_q == IDLE;
   assign bus.done = done_q;
   assign bus.result = res_q;
   assign bus.sign = sign_q;
   assign bus.overflow = ovf_q;
   assign bus.carry_out = cout_q;
   assign bus.zero = zero_q;
endmodule
